mux16_rr_arbiter: RTL and testbench
===================================

# mux16_rr_arbiter

Round-robin arbiter and select controller for a 16-input, 4-bit-select multiplexer. It shares one 16:1 mux path between 16 requesters. It grants one requester at a time, drives the mux `sel` with the grantee's index, and holds it until the grantee releases or a hold timeout forces preemption. It sits directly in front of the mux: `sel` connects straight to the mux select, and `grant` returns to the requesters.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive cycles a grantee may own the mux. Legal range 1..255.

Ports:
- `clk`  in  1  single clock. All state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  16  request per requester; bit i requests input i.
- `release`  in  1  the current grantee ends its ownership; ignored when not owning.
- `sel`  out  4  mux select, registered; index of the current or most recent grantee.
- `grant`  out  16  one-hot grant, registered; all-zero when not owning.
- `busy`  out  1  high while a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant was ended by the hold limit.

## Operation
- Internal state:
  - FSM {IDLE, OWNED};
  - 4-bit round-robin pointer `ptr`;
  - 8-bit hold counter `cnt`.
- Reset values: state=IDLE, `ptr`=0, `cnt`=0, `sel`=0, `grant`=0, `busy`=0, `timeout`=0.
- IDLE:
  - `grant`=0, `busy`=0.
  - If `req`≠0, the winner is the first set bit scanning upward from `ptr` with wrap 15→0.
  - Next edge: `sel`=winner, `grant`=1<<winner, `busy`=1, `cnt`=0, state=OWNED.
  - If `req`=0, stay in IDLE; `sel` holds its last value.
- OWNED:
  - `cnt` increments each cycle.
  - Exit conditions, evaluated at each edge:
    - (a) `release`=1;
    - (b) `req[sel]`=0, i.e. the requester withdrew, treated as a release;
    - (c) `cnt`==`MAX_HOLD`-1 with neither (a) nor (b) true. This is a forced exit.
  - On exit: state=IDLE, `grant`=0, `busy`=0, `ptr`=(`sel`+1) mod 16 (4-bit wrap), `sel` unchanged.
  - `timeout`=1 for exactly the first IDLE cycle, and only on exit (c).
- Simultaneous events:
  - `release` and limit reached in the same cycle: normal release, no `timeout` pulse.
  - Requests from other inputs during OWNED are ignored until the next IDLE cycle.
- Fairness: every exit passes through at least one IDLE cycle, so other requesters can win. The releasing requester has lowest priority in the next arbitration.
- `MAX_HOLD`=1: every grant lasts exactly one cycle. It exits via (c) unless released or withdrawn in that cycle.
- Asserting `rst` mid-grant immediately (asynchronously) returns all state and outputs to their reset values. This includes `ptr`=0.

## Timing
- Request to grant: `req` sampled high at edge N in IDLE → `grant`, `sel`, `busy` valid after edge N (1-cycle latency).
- Release to grant drop: `release` sampled at edge M → `grant`=0 after edge M.
- Next grant appears after edge M+1. Back-to-back turnaround is 2 cycles: one IDLE gap.
- Maximum grant length is `MAX_HOLD` cycles.
- `timeout` is high during the cycle following a forced exit's edge, coincident with the IDLE gap.
- `sel` changes only on grant entry, never during OWNED or IDLE.
- All outputs are registered, with no combinational path from inputs.

## Test plan
- Reset: assert `rst` asynchronously between edges → `sel`=0, `grant`=0x0000, `busy`=0, `timeout`=0 immediately. Release `rst`; with `req`=0 the outputs stay put for 10 cycles.
- Single requester: `req`=0x0020 → one cycle later `sel`=5, `grant`=0x0020, `busy`=1. Pulse `release` → `grant`=0x0000 next cycle. `sel` stays 5.
- Full contention, `MAX_HOLD`=16: `req`=0xFFFF, `release` pulsed on the 3rd owned cycle of each grant → grant order `sel`=0,1,2,…,15,0, each separated by one IDLE cycle.
- Wrap-around: after a grant to 15, `req`=0x8008 → next `sel`=3. Then after 3 releases, `req`=0x8008 → `sel`=15.
- Timeout, `MAX_HOLD`=4: `req`=0x0003 held, no `release` → `sel`=0 granted exactly 4 cycles, `timeout`=1 for one cycle, then `sel`=1. `release` on the 4th cycle produces no `timeout` pulse.
- Withdraw and reset mid-grant: grantee drops `req` → grant ends after the next edge with no `timeout`. `rst` asserted during OWNED with `ptr`=9 → afterwards `req`=0xFFFF grants `sel`=0.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 16:1 mux.
// One grantee at a time; ownership ends on release, withdrawal, or hold timeout.
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        release_grant,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    localparam logic [7:0] CntLimit = 8'(MAX_HOLD - 1);

    state_e      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;

    logic [31:0] req_dbl;
    logic [15:0] req_rot;
    logic [3:0]  win_off;
    logic [3:0]  winner;
    logic        any_req;
    logic        owner_done;
    logic        limit_hit;

    // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[15:0];
        win_off = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 4'(k);
            end
        end
        winner  = ptr_q + win_off;
        any_req = |req;
    end

    // A withdrawn request counts as a release, which also suppresses the timeout pulse.
    assign owner_done = release_grant | ~req[sel_q];
    assign limit_hit  = (cnt_q == CntLimit);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_d = 16'h0000;
                busy_d  = 1'b0;
                if (any_req) begin
                    sel_d   = winner;
                    grant_d = 16'h0001 << winner;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StOwned;
                end
            end
            StOwned: begin
                if (owner_done || limit_hit) begin
                    state_d   = StIdle;
                    grant_d   = 16'h0000;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + 4'd1;
                    timeout_d = ~owner_done;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 4'd0;
            cnt_q     <= 8'd0;
            sel_q     <= 4'd0;
            grant_q   <= 16'h0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: two instances (hold limits 16 and 4) checked each cycle
// against an owner/hold-count reference model, plus directed scenario checks.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req16, req4;
    logic        rel16, rel4;
    logic [3:0]  sel16, sel4;
    logic [15:0] grant16, grant4;
    logic        busy16, busy4;
    logic        timeout16, timeout4;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = MAX_HOLD 16, index 1 = MAX_HOLD 4.
    int m_owner [2];
    int m_held  [2];
    int m_ptr   [2];
    int m_sel   [2];
    int m_tmo   [2];
    int m_max   [2] = '{16, 4};

    mux16_rr_arbiter #(.MAX_HOLD(16)) dut16 (
        .clk           (clk),
        .rst           (rst),
        .req           (req16),
        .release_grant (rel16),
        .sel           (sel16),
        .grant         (grant16),
        .busy          (busy16),
        .timeout       (timeout16)
    );

    mux16_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .req           (req4),
        .release_grant (rel4),
        .sel           (sel4),
        .grant         (grant4),
        .busy          (busy4),
        .timeout       (timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_ptr[d]   = 0;
            m_sel[d]   = 0;
            m_tmo[d]   = 0;
        end
    endtask

    task automatic m_step(input int d, input logic [15:0] r, input logic rl);
        if (m_owner[d] < 0) begin
            m_tmo[d] = 0;
            for (int k = 0; k < 16; k++) begin
                int idx;
                idx = (m_ptr[d] + k) % 16;
                if (r[idx]) begin
                    m_owner[d] = idx;
                    m_sel[d]   = idx;
                    m_held[d]  = 1;
                    break;
                end
            end
        end else if (rl || !r[m_owner[d]]) begin
            m_ptr[d]   = (m_owner[d] + 1) % 16;
            m_owner[d] = -1;
            m_tmo[d]   = 0;
        end else if (m_held[d] == m_max[d]) begin
            m_ptr[d]   = (m_owner[d] + 1) % 16;
            m_owner[d] = -1;
            m_tmo[d]   = 1;
        end else begin
            m_held[d]  = m_held[d] + 1;
        end
    endtask

    function automatic logic [31:0] m_grant(input int d);
        return (m_owner[d] < 0) ? 32'h0 : (32'h1 << m_owner[d]);
    endfunction

    task automatic check_all();
        chk("sel16",     32'(sel16),     32'(m_sel[0]));
        chk("grant16",   32'(grant16),   m_grant(0));
        chk("busy16",    32'(busy16),    32'(m_owner[0] >= 0));
        chk("timeout16", 32'(timeout16), 32'(m_tmo[0]));
        chk("sel4",      32'(sel4),      32'(m_sel[1]));
        chk("grant4",    32'(grant4),    m_grant(1));
        chk("busy4",     32'(busy4),     32'(m_owner[1] >= 0));
        chk("timeout4",  32'(timeout4),  32'(m_tmo[1]));
    endtask

    task automatic tick();
        m_step(0, req16, rel16);
        m_step(1, req4, rel4);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset between edges and verify outputs clear without a clock edge.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        chk("rst_async_grant16", 32'(grant16), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    // One grant to dut16, released on its 3rd owned cycle.
    task automatic grant_cycle(input int exp_sel);
        tick();
        chk("gc_sel", 32'(sel16), 32'(exp_sel));
        chk("gc_busy", 32'(busy16), 32'h1);
        tick();
        tick();
        rel16 = 1'b1;
        tick();
        rel16 = 1'b0;
        chk("gc_gap_busy", 32'(busy16), 32'h0);
        chk("gc_gap_sel", 32'(sel16), 32'(exp_sel));
    endtask

    initial begin
        rst   = 1'b1;
        req16 = 16'h0;
        rel16 = 1'b0;
        req4  = 16'h0;
        rel4  = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        repeat (10) tick();

        // Single requester
        req16 = 16'h0020;
        tick();
        chk("single_sel", 32'(sel16), 32'd5);
        chk("single_grant", 32'(grant16), 32'h0020);
        chk("single_busy", 32'(busy16), 32'h1);
        rel16 = 1'b1;
        tick();
        rel16 = 1'b0;
        req16 = 16'h0;
        chk("single_drop", 32'(grant16), 32'h0);
        chk("single_sel_hold", 32'(sel16), 32'd5);
        tick();

        // Full contention from a fresh pointer, then wrap-around
        do_reset();
        req16 = 16'hFFFF;
        for (int g = 0; g < 16; g++) grant_cycle(g);
        req16 = 16'h8008;
        grant_cycle(3);
        grant_cycle(15);

        // Withdrawal ends the grant without a timeout
        req16 = 16'h0004;
        tick();
        chk("wd_sel", 32'(sel16), 32'd2);
        req16 = 16'h0;
        tick();
        chk("wd_busy", 32'(busy16), 32'h0);
        chk("wd_timeout", 32'(timeout16), 32'h0);

        // Reset during a grant with the pointer at 9 restores pointer 0
        req16 = 16'h0100;
        grant_cycle(8);
        req16 = 16'hFFFF;
        tick();
        chk("pre_rst_sel", 32'(sel16), 32'd9);
        do_reset();
        chk("rst_sel", 32'(sel16), 32'd0);
        chk("rst_busy", 32'(busy16), 32'h0);
        tick();
        chk("post_rst_sel", 32'(sel16), 32'd0);
        chk("post_rst_grant", 32'(grant16), 32'h0001);
        rel16 = 1'b1;
        tick();
        rel16 = 1'b0;
        req16 = 16'h0;
        tick();

        // Hold timeout with MAX_HOLD 4
        req4 = 16'h0003;
        tick();
        chk("to_sel0", 32'(sel4), 32'd0);
        chk("to_busy0", 32'(busy4), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold", 32'(busy4), 32'h1);
        end
        tick();
        chk("to_exit_busy", 32'(busy4), 32'h0);
        chk("to_pulse", 32'(timeout4), 32'h1);
        tick();
        chk("to_next_sel", 32'(sel4), 32'd1);
        chk("to_pulse_end", 32'(timeout4), 32'h0);
        repeat (3) tick();
        rel4 = 1'b1;
        tick();
        rel4 = 1'b0;
        req4 = 16'h0;
        chk("rel_at_limit_busy", 32'(busy4), 32'h0);
        chk("rel_at_limit_no_to", 32'(timeout4), 32'h0);
        tick();

        // Randomized traffic on both instances
        for (int i = 0; i < 500; i++) begin
            req16 = 16'($urandom & $urandom);
            rel16 = ($urandom_range(3) == 0);
            req4  = 16'($urandom & $urandom);
            rel4  = ($urandom_range(3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
